// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush/redirect controller.
//   - ctrl_state_e : trap-entry sequencer states
//   - CSR_MEPC / CSR_MCAUSE : CSR addresses written during trap entry
//   - IRQ_CAUSE_M_EXT : mcause code for a machine external interrupt
//   - STALL_* : bit positions inside the stall vector
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN     = 2'd0,
    CTRL_T_MEPC  = 2'd1,
    CTRL_T_CAUSE = 2'd2
  } ctrl_state_e;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  // Interrupt bit set, exception code 11 (machine external interrupt).
  localparam logic [31:0] IRQ_CAUSE_M_EXT = 32'h8000_000B;

  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;

endpackage

// File: rtl/pipe_ctrl.sv
// Central stall/flush/redirect controller for a 5-stage pipeline.
// Arbitrates trap, interrupt, mret, branch, EX-busy and load-use hazards
// (highest priority first) and sequences trap entry by writing mepc and
// then mcause over the single CSR write port.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   stallreq_id/_ex          load-use hazard / multi-cycle EX busy
//   branch_taken_ex/_target  taken branch resolved in EX and its target
//   exc_req_mem/_cause_mem   synchronous exception in MEM and its code
//   mret_mem, mem_valid      mret in MEM / MEM holds a real instruction
//   mem_pc                   PC of the MEM instruction
//   irq_pending, irq_en      external interrupt pending / enabled
//   csr_mtvec, csr_mepc      trap vector / return PC
//   stall[4:0]               pc, if_id, id_ex, ex_mem, mem_wb hold
//   flush_*                  load bubble into the named pipeline register
//   redirect_en/_pc          PC takes redirect_pc on the next edge
//   trap_csr_wr_*            CSR write port used during trap entry
//   busy                     trap-entry sequence in progress
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter int               CSR_AW      = 12,
  parameter logic [CSR_AW-1:0] MEPC_ADDR   = CSR_AW'(CSR_MEPC),
  parameter logic [CSR_AW-1:0] MCAUSE_ADDR = CSR_AW'(CSR_MCAUSE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              branch_taken_ex,
  input  logic [XLEN-1:0]   branch_target_ex,
  input  logic              exc_req_mem,
  input  logic [XLEN-1:0]   exc_cause_mem,
  input  logic              mret_mem,
  input  logic              mem_valid,
  input  logic [XLEN-1:0]   mem_pc,
  input  logic              irq_pending,
  input  logic              irq_en,
  input  logic [XLEN-1:0]   csr_mtvec,
  input  logic [XLEN-1:0]   csr_mepc,
  output logic [4:0]        stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic              flush_mem_wb,
  output logic              redirect_en,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              trap_csr_wr_en,
  output logic [CSR_AW-1:0] trap_csr_wr_addr,
  output logic [XLEN-1:0]   trap_csr_wr_data,
  output logic              busy
);

  localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, (XLEN-1)'(11)};

  ctrl_state_e     state_q, state_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic [XLEN-1:0] trap_cause_q, trap_cause_d;

  logic exc_take;
  logic irq_take;

  // An interrupt never preempts an mret in MEM, so the handler cannot be
  // re-entered before the return completes.
  assign exc_take = exc_req_mem & mem_valid;
  assign irq_take = irq_pending & irq_en & mem_valid & ~mret_mem;

  always_comb begin
    state_d          = state_q;
    trap_pc_d        = trap_pc_q;
    trap_cause_d     = trap_cause_q;
    stall            = '0;
    flush_if_id      = 1'b0;
    flush_id_ex      = 1'b0;
    flush_ex_mem     = 1'b0;
    flush_mem_wb     = 1'b0;
    redirect_en      = 1'b0;
    redirect_pc      = '0;
    trap_csr_wr_en   = 1'b0;
    trap_csr_wr_addr = '0;
    trap_csr_wr_data = '0;
    busy             = 1'b0;

    if (rst) begin
      busy = (state_q != CTRL_RUN);
      case (state_q)
        CTRL_RUN: begin
          if (exc_take || irq_take) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
            redirect_en  = 1'b1;
            redirect_pc  = csr_mtvec;
            trap_pc_d    = mem_pc;
            trap_cause_d = exc_take ? exc_cause_mem : IRQ_CAUSE;
            state_d      = CTRL_T_MEPC;
          end else if (mret_mem) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            redirect_en  = 1'b1;
            redirect_pc  = csr_mepc;
          end else if (branch_taken_ex) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            redirect_en  = 1'b1;
            redirect_pc  = branch_target_ex;
          end else if (stallreq_ex) begin
            // Freeze everything up to EX; MEM gets a bubble and drains to WB.
            stall[STALL_PC]     = 1'b1;
            stall[STALL_IF_ID]  = 1'b1;
            stall[STALL_ID_EX]  = 1'b1;
            stall[STALL_EX_MEM] = 1'b1;
            flush_ex_mem        = 1'b1;
          end else if (stallreq_id) begin
            stall[STALL_PC]    = 1'b1;
            stall[STALL_IF_ID] = 1'b1;
            flush_id_ex        = 1'b1;
          end
        end
        CTRL_T_MEPC: begin
          // Hold the handler fetch out of decode until both CSRs commit.
          stall[STALL_PC]  = 1'b1;
          flush_if_id      = 1'b1;
          trap_csr_wr_en   = 1'b1;
          trap_csr_wr_addr = MEPC_ADDR;
          trap_csr_wr_data = trap_pc_q;
          state_d          = CTRL_T_CAUSE;
        end
        CTRL_T_CAUSE: begin
          stall[STALL_PC]  = 1'b1;
          flush_if_id      = 1'b1;
          trap_csr_wr_en   = 1'b1;
          trap_csr_wr_addr = MCAUSE_ADDR;
          trap_csr_wr_data = trap_cause_q;
          state_d          = CTRL_RUN;
        end
        default: state_d = CTRL_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= CTRL_RUN;
      trap_pc_q    <= '0;
      trap_cause_q <= '0;
    end else begin
      state_q      <= state_d;
      trap_pc_q    <= trap_pc_d;
      trap_cause_q <= trap_cause_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, branch_taken_ex;
  logic [31:0] branch_target_ex;
  logic        exc_req_mem;
  logic [31:0] exc_cause_mem;
  logic        mret_mem, mem_valid;
  logic [31:0] mem_pc;
  logic        irq_pending, irq_en;
  logic [31:0] csr_mtvec, csr_mepc;
  logic [4:0]  stall;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        trap_csr_wr_en;
  logic [11:0] trap_csr_wr_addr;
  logic [31:0] trap_csr_wr_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .branch_taken_ex(branch_taken_ex), .branch_target_ex(branch_target_ex),
    .exc_req_mem(exc_req_mem), .exc_cause_mem(exc_cause_mem),
    .mret_mem(mret_mem), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .irq_pending(irq_pending), .irq_en(irq_en),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .stall(stall),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .trap_csr_wr_en(trap_csr_wr_en), .trap_csr_wr_addr(trap_csr_wr_addr),
    .trap_csr_wr_data(trap_csr_wr_data), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending CSR writes are a queue: a trap enqueues mepc then mcause, and
  // while anything is queued the controller emits one write per cycle and
  // ignores every other request.
  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } csr_wr_t;

  csr_wr_t wq[$];

  typedef struct packed {
    logic [4:0]  stall;
    logic [3:0]  flush;   // {if_id, id_ex, ex_mem, mem_wb}
    logic        redir;
    logic [31:0] rpc;
    logic        wen;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        busy;
  } outs_t;

  outs_t exp_o, act_o;
  logic  trap_now;
  logic [31:0] trap_cause_now;

  always @(negedge clk) begin
    exp_o = '0;
    trap_now = 1'b0;
    trap_cause_now = '0;
    if (rst !== 1'b1) begin
      // everything forced low
    end else if (wq.size() > 0) begin
      exp_o.stall = 5'b00001;
      exp_o.flush = 4'b1000;
      exp_o.wen   = 1'b1;
      exp_o.waddr = wq[0].addr;
      exp_o.wdata = wq[0].data;
      exp_o.busy  = 1'b1;
    end else if ((exc_req_mem && mem_valid) ||
                 (irq_pending && irq_en && mem_valid && !mret_mem)) begin
      exp_o.flush = 4'b1111;
      exp_o.redir = 1'b1;
      exp_o.rpc   = csr_mtvec;
      trap_now    = 1'b1;
      trap_cause_now = (exc_req_mem && mem_valid) ? exc_cause_mem : 32'h8000_000B;
    end else if (mret_mem) begin
      exp_o.flush = 4'b1110;
      exp_o.redir = 1'b1;
      exp_o.rpc   = csr_mepc;
    end else if (branch_taken_ex) begin
      exp_o.flush = 4'b1100;
      exp_o.redir = 1'b1;
      exp_o.rpc   = branch_target_ex;
    end else if (stallreq_ex) begin
      exp_o.stall = 5'b01111;
      exp_o.flush = 4'b0010;
    end else if (stallreq_id) begin
      exp_o.stall = 5'b00011;
      exp_o.flush = 4'b0100;
    end

    act_o = '{stall, {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb},
              redirect_en, redirect_pc, trap_csr_wr_en, trap_csr_wr_addr,
              trap_csr_wr_data, busy};
    checks++;
    if (act_o !== exp_o) begin
      errors++;
      $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act_o, exp_o);
    end

    // advance model to the next cycle
    if (rst !== 1'b1) wq.delete();
    else if (wq.size() > 0) void'(wq.pop_front());
    else if (trap_now) begin
      wq.push_back('{addr: 12'h341, data: mem_pc});
      wq.push_back('{addr: 12'h342, data: trap_cause_now});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_id = 0; stallreq_ex = 0; branch_taken_ex = 0; branch_target_ex = 0;
    exc_req_mem = 0; exc_cause_mem = 0; mret_mem = 0; mem_valid = 0; mem_pc = 0;
    irq_pending = 0; irq_en = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    clear_inputs();
    csr_mtvec = 32'h200;
    csr_mepc  = 32'h444;
    // Reset: inputs that would otherwise act must produce nothing.
    stallreq_ex = 1; branch_taken_ex = 1;
    next_cycle();
    @(negedge clk);
    chk("reset_stall", {27'd0, stall}, 32'h0);
    chk("reset_redirect", {31'd0, redirect_en}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    next_cycle();
    clear_inputs();
    rst = 1'b1;

    // Load-use for one cycle
    stallreq_id = 1;
    @(negedge clk);
    chk("loaduse_stall", {27'd0, stall}, 32'h3);
    chk("loaduse_flush_id_ex", {31'd0, flush_id_ex}, 32'h1);
    next_cycle();
    stallreq_id = 0;
    @(negedge clk);
    chk("loaduse_after", {27'd0, stall}, 32'h0);
    next_cycle();

    // EX busy for 3 cycles, load-use also raised
    stallreq_ex = 1; stallreq_id = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("exbusy_stall", {27'd0, stall}, 32'h0F);
      chk("exbusy_flush_ex_mem", {31'd0, flush_ex_mem}, 32'h1);
      chk("exbusy_flush_id_ex", {31'd0, flush_id_ex}, 32'h0);
      next_cycle();
    end
    stallreq_ex = 0; stallreq_id = 0;
    @(negedge clk);
    chk("exbusy_after", {27'd0, stall}, 32'h0);
    next_cycle();

    // Branch beats EX busy
    branch_taken_ex = 1; branch_target_ex = 32'h80; stallreq_ex = 1;
    @(negedge clk);
    chk("branch_pc", redirect_pc, 32'h80);
    chk("branch_flush", {30'd0, flush_if_id, flush_id_ex}, 32'h3);
    chk("branch_stall", {27'd0, stall}, 32'h0);
    next_cycle();
    clear_inputs();

    // Exception without mem_valid is a bubble: ignored
    exc_req_mem = 1; exc_cause_mem = 32'd5;
    @(negedge clk);
    chk("exc_bubble_redirect", {31'd0, redirect_en}, 32'h0);
    next_cycle();

    // Exception trap entry
    mem_valid = 1; mem_pc = 32'h104; exc_cause_mem = 32'd2;
    @(negedge clk);
    chk("trap_redirect_pc", redirect_pc, 32'h200);
    chk("trap_flush_all", {28'd0, flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb}, 32'hF);
    next_cycle();
    clear_inputs();
    branch_taken_ex = 1; branch_target_ex = 32'h999; // must be ignored
    @(negedge clk);
    chk("trap_n1_addr", {20'd0, trap_csr_wr_addr}, 32'h341);
    chk("trap_n1_data", trap_csr_wr_data, 32'h104);
    chk("trap_n1_busy", {31'd0, busy}, 32'h1);
    chk("trap_n1_redirect", {31'd0, redirect_en}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("trap_n2_addr", {20'd0, trap_csr_wr_addr}, 32'h342);
    chk("trap_n2_data", trap_csr_wr_data, 32'h2);
    chk("trap_n2_busy", {31'd0, busy}, 32'h1);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("trap_n3_busy", {31'd0, busy}, 32'h0);
    next_cycle();

    // mret beats interrupt; next cycle the interrupt is taken
    irq_pending = 1; irq_en = 1; mret_mem = 1; mem_valid = 1; mem_pc = 32'h300;
    @(negedge clk);
    chk("mret_pc", redirect_pc, 32'h444);
    chk("mret_flush_mem_wb", {31'd0, flush_mem_wb}, 32'h0);
    chk("mret_flush_ex_mem", {31'd0, flush_ex_mem}, 32'h1);
    next_cycle();
    mret_mem = 0;
    @(negedge clk);
    chk("irq_redirect_pc", redirect_pc, 32'h200);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("irq_mepc_data", trap_csr_wr_data, 32'h300);
    next_cycle();
    @(negedge clk);
    chk("irq_mcause_data", trap_csr_wr_data, 32'h8000_000B);
    next_cycle();

    // Interrupt disabled: nothing happens
    irq_pending = 1; mem_valid = 1;
    @(negedge clk);
    chk("irq_disabled", {31'd0, redirect_en}, 32'h0);
    next_cycle();
    clear_inputs();

    // Reset during T_MEPC aborts the sequence
    exc_req_mem = 1; mem_valid = 1; mem_pc = 32'h510; exc_cause_mem = 32'd7;
    next_cycle();
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_during_rst_wen", {31'd0, trap_csr_wr_en}, 32'h0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'h0);
    chk("abort_wen", {31'd0, trap_csr_wr_en}, 32'h0);
    chk("abort_stall", {27'd0, stall}, 32'h0);
    next_cycle();
    next_cycle();

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
